// File: rtl/req_arbiter.sv
// req_arbiter: a 4-requester arbiter built around a three-state FSM (IDLE, GRANT, RELEASE).
// Each grant is held for at most MAX_HOLD cycles. When the hold limit revokes a grant,
// the block raises a one-cycle timeout pulse.
// Optional build macro: ARB_ROUND_ROBIN_EN.
//   - Defined: round-robin selection, searching upward from the requester after the last winner.
//   - Undefined: fixed priority, where bit 3 wins.
module req_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       busy,
  output logic       timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_REL   = 2'd2;

  logic [1:0] state;
  logic [7:0] hold_cnt;
  logic [1:0] win_id;
  logic       withdraw, hold_lim, grant_exit, to_exit;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] last_id;

  // Round-robin winner: the first set bit searching upward from last_id+1.
  // The loop runs from the back of the search order to the front, so the
  // earliest set bit is the final assignment and wins.
  always_comb begin
    win_id = 2'd0;
    for (int i = 4; i >= 1; i--)
      if (req[last_id + 2'(i)]) win_id = last_id + 2'(i);
  end
`else
  // Fixed-priority winner: the highest set bit overrides the lower ones.
  always_comb begin
    win_id = 2'd0;
    for (int i = 0; i < 4; i++)
      if (req[i]) win_id = 2'(i);
  end
`endif

  // Exit conditions for GRANT.
  // The hold-limit exit counts as a timeout only when done is low and the
  // requester has not withdrawn on the same edge.
  always_comb begin
    withdraw   = ~req[gnt_id];
    hold_lim   = (hold_cnt == 8'(MAX_HOLD - 1));
    grant_exit = done | withdraw | hold_lim;
    to_exit    = hold_lim & ~done & ~withdraw;
  end

  assign gnt_valid = |gnt;
  assign busy      = (state != S_IDLE);

  // FSM with registered grant outputs; reset clears the grant immediately, with no RELEASE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      gnt      <= 4'b0;
      gnt_id   <= 2'd0;
      hold_cnt <= 8'd0;
      timeout  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_id  <= 2'd3;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          timeout <= 1'b0;
          if (enable && (req != 4'b0)) begin
            state    <= S_GRANT;
            gnt      <= 4'b1 << win_id;
            gnt_id   <= win_id;
            hold_cnt <= 8'd0;
          end
        end
        S_GRANT: begin
          if (grant_exit) begin
            state   <= S_REL;
            gnt     <= 4'b0;
            timeout <= to_exit;
`ifdef ARB_ROUND_ROBIN_EN
            last_id <= gnt_id;
`endif
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        S_REL: begin
          state   <= S_IDLE;
          timeout <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          gnt     <= 4'b0;
          timeout <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_arbiter.sv
// Directed bench for req_arbiter, built with MAX_HOLD=4.
// Each cycle it compares the packed vector {gnt, gnt_id, gnt_valid, busy, timeout}
// against a hand-computed value, sampled 1ns after the rising edge.
module tb_req_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       done = 1'b0;
  logic [3:0] req = 4'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid, busy, timeout;
  logic [8:0] obs;
  int         total = 0;
  int         passed = 0;

  always #5 clk = ~clk;

  req_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .busy(busy), .timeout(timeout)
  );

  assign obs = {gnt, gnt_id, gnt_valid, busy, timeout};

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; #1;
    total++; if (obs !== 9'b0) $display("FAIL reset_async got=%b exp=%b", obs, 9'b0); else passed++;
    tick;
    total++; if (obs !== 9'b0) $display("FAIL reset_held got=%b exp=%b", obs, 9'b0); else passed++;
    rst_n = 1'b1;
    tick;
    total++; if (obs !== 9'b0) $display("FAIL reset_idle got=%b exp=%b", obs, 9'b0); else passed++;
  endtask

`ifndef ARB_ROUND_ROBIN_EN
  task automatic test_fixed;
    logic [8:0] g = {4'b0100, 2'd2, 3'b110};
    enable = 1'b1; req = 4'b0110; done = 1'b0;
    tick;
    total++; if (obs !== g) $display("FAIL fixed_g1 got=%b exp=%b", obs, g); else passed++;
    req = 4'b1110;  // a higher-priority request arriving mid-grant must not steal it
    tick;
    total++; if (obs !== g) $display("FAIL fixed_g2 got=%b exp=%b", obs, g); else passed++;
    tick;
    total++; if (obs !== g) $display("FAIL fixed_g3 got=%b exp=%b", obs, g); else passed++;
    done = 1'b1;
    tick;
    total++; if (obs !== {4'b0, 2'd2, 3'b010}) $display("FAIL fixed_rel got=%b exp=%b", obs, {4'b0, 2'd2, 3'b010}); else passed++;
    done = 1'b0; req = 4'b0;
    tick;
    total++; if (obs !== {4'b0, 2'd2, 3'b000}) $display("FAIL fixed_idle got=%b exp=%b", obs, {4'b0, 2'd2, 3'b000}); else passed++;
  endtask
`endif

  task automatic test_timeout;
    enable = 1'b1; req = 4'b0001; done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick;
      total++; if (obs !== {4'b0001, 2'd0, 3'b110}) $display("FAIL to_grant%0d got=%b exp=%b", c, obs, {4'b0001, 2'd0, 3'b110}); else passed++;
    end
    tick;
    total++; if (obs !== {4'b0, 2'd0, 3'b011}) $display("FAIL to_pulse got=%b exp=%b", obs, {4'b0, 2'd0, 3'b011}); else passed++;
    tick;
    total++; if (obs !== {4'b0, 2'd0, 3'b000}) $display("FAIL to_idle got=%b exp=%b", obs, {4'b0, 2'd0, 3'b000}); else passed++;
    tick;
    total++; if (obs !== {4'b0001, 2'd0, 3'b110}) $display("FAIL to_regrant got=%b exp=%b", obs, {4'b0001, 2'd0, 3'b110}); else passed++;
    req = 4'b0;
    tick;
    total++; if (obs !== {4'b0, 2'd0, 3'b010}) $display("FAIL to_regrant_rel got=%b exp=%b", obs, {4'b0, 2'd0, 3'b010}); else passed++;
    tick;
  endtask

  // Both done and withdrawal on the hold-limit cycle give a normal exit with no timeout pulse.
  task automatic test_coincide;
    for (int m = 0; m < 2; m++) begin
      req = 4'b0001; enable = 1'b1;
      for (int c = 0; c < 4; c++) tick;
      total++; if (obs !== {4'b0001, 2'd0, 3'b110}) $display("FAIL coin%0d_last got=%b exp=%b", m, obs, {4'b0001, 2'd0, 3'b110}); else passed++;
      if (m == 0) done = 1'b1; else req = 4'b0;
      tick;
      total++; if (obs !== {4'b0, 2'd0, 3'b010}) $display("FAIL coin%0d_rel got=%b exp=%b", m, obs, {4'b0, 2'd0, 3'b010}); else passed++;
      done = 1'b0; req = 4'b0;
      tick;
    end
  endtask

  task automatic test_enable;
    enable = 1'b0; req = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      tick;
      total++; if (obs !== {4'b0, 2'd0, 3'b000}) $display("FAIL en_block%0d got=%b exp=%b", c, obs, {4'b0, 2'd0, 3'b000}); else passed++;
    end
    enable = 1'b1;
    tick;
    total++; if (obs !== {4'b1000, 2'd3, 3'b110}) $display("FAIL en_grant got=%b exp=%b", obs, {4'b1000, 2'd3, 3'b110}); else passed++;
    enable = 1'b0;
    tick;
    total++; if (obs !== {4'b1000, 2'd3, 3'b110}) $display("FAIL en_midgrant got=%b exp=%b", obs, {4'b1000, 2'd3, 3'b110}); else passed++;
    done = 1'b1;
    tick;
    total++; if (obs !== {4'b0, 2'd3, 3'b010}) $display("FAIL en_rel got=%b exp=%b", obs, {4'b0, 2'd3, 3'b010}); else passed++;
    done = 1'b0;
    tick;
    tick;
    total++; if (obs !== {4'b0, 2'd3, 3'b000}) $display("FAIL en_stay_idle got=%b exp=%b", obs, {4'b0, 2'd3, 3'b000}); else passed++;
    req = 4'b0; enable = 1'b1;
  endtask

  task automatic test_withdraw;
    req = 4'b0010;
    tick;
    total++; if (obs !== {4'b0010, 2'd1, 3'b110}) $display("FAIL wd_g1 got=%b exp=%b", obs, {4'b0010, 2'd1, 3'b110}); else passed++;
    tick;
    total++; if (obs !== {4'b0010, 2'd1, 3'b110}) $display("FAIL wd_g2 got=%b exp=%b", obs, {4'b0010, 2'd1, 3'b110}); else passed++;
    req = 4'b0;
    tick;
    total++; if (obs !== {4'b0, 2'd1, 3'b010}) $display("FAIL wd_rel got=%b exp=%b", obs, {4'b0, 2'd1, 3'b010}); else passed++;
    tick;
    total++; if (obs !== {4'b0, 2'd1, 3'b000}) $display("FAIL wd_idle got=%b exp=%b", obs, {4'b0, 2'd1, 3'b000}); else passed++;
  endtask

  task automatic test_reset_mid_grant;
    req = 4'b0100; enable = 1'b1;
    tick;
    total++; if (obs !== {4'b0100, 2'd2, 3'b110}) $display("FAIL rm_grant got=%b exp=%b", obs, {4'b0100, 2'd2, 3'b110}); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (obs !== 9'b0) $display("FAIL rm_async got=%b exp=%b", obs, 9'b0); else passed++;
    tick;
    total++; if (obs !== 9'b0) $display("FAIL rm_held got=%b exp=%b", obs, 9'b0); else passed++;
    rst_n = 1'b1;
    tick;
    total++; if (obs !== {4'b0100, 2'd2, 3'b110}) $display("FAIL rm_regrant got=%b exp=%b", obs, {4'b0100, 2'd2, 3'b110}); else passed++;
    req = 4'b0;
    tick;
    tick;
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  task automatic test_rr;
    int         e[5] = '{0, 1, 2, 3, 0};
    logic [8:0] x;
    rst_n = 1'b0; #1; rst_n = 1'b1;
    req = 4'b1111; enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      x = {4'(1 << e[k]), 2'(e[k]), 3'b110};
      total++; if (obs !== x) $display("FAIL rr_grant%0d got=%b exp=%b", k, obs, x); else passed++;
      done = 1'b1;
      tick;
      x = {4'b0, 2'(e[k]), 3'b010};
      total++; if (obs !== x) $display("FAIL rr_rel%0d got=%b exp=%b", k, obs, x); else passed++;
      done = 1'b0;
      tick;
    end
    req = 4'b0;
  endtask
`endif

  initial begin
    test_reset;
`ifndef ARB_ROUND_ROBIN_EN
    test_fixed;
`endif
    test_timeout;
    test_coincide;
    test_enable;
    test_withdraw;
    test_reset_mid_grant;
`ifdef ARB_ROUND_ROBIN_EN
    test_rr;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/req_arbiter.md
REQ_ARBITER -- requirements
Module: req_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, is the maximum number of cycles one grant is held; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 enable  input  1  high permits new grants; low blocks new grants only.
REQ-005 req  input  4  request vector, one bit per requester; bit 3 has highest fixed priority.
REQ-006 done  input  1  resource signals that the current transfer is finished; sampled only in GRANT.
REQ-007 gnt  output  4  one-hot grant vector, registered.
REQ-008 gnt_id  output  2  encoded index of the granted requester, registered.
REQ-009 gnt_valid  output  1  high exactly when gnt is non-zero.
REQ-010 busy  output  1  high in the GRANT and RELEASE states.
REQ-011 timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT and RELEASE.
REQ-013 IDLE -> GRANT when enable=1 and req!=0; otherwise the FSM SHALL stay in IDLE.
- Winner selection uses req on that edge.
- gnt, gnt_id and gnt_valid appear on the next cycle (latency 1 from req).
REQ-014 In GRANT, gnt, gnt_id and gnt_valid SHALL hold their value; enable has no effect.
REQ-015 hold_cnt SHALL reset to 0 on GRANT entry and increment every GRANT cycle; its width is 8 bits.
REQ-016 GRANT -> RELEASE on the first of these conditions:
- done=1;
- req[gnt_id]=0 (requester withdrew);
- hold_cnt==MAX_HOLD-1 (timeout).
REQ-017 If done=1 or the withdrawal coincides with the hold limit, the exit is normal and timeout SHALL stay 0.
REQ-018 On a timeout exit, timeout SHALL be 1 for exactly the first RELEASE cycle.
REQ-019 RELEASE lasts exactly one cycle, then -> IDLE. In RELEASE:
- gnt=0, gnt_valid=0, gnt_id keeps the last winner;
- last_id is updated to gnt_id.
REQ-020 Two consecutive grants are therefore separated by at least 2 cycles with gnt=0 (RELEASE, IDLE).
REQ-021 gnt SHALL never have more than one bit set.
REQ-022 Request bits that change in GRANT or RELEASE SHALL NOT affect the current grant, except the withdrawal rule in REQ-016.

Reset
REQ-023 When rst_n=0, the block SHALL immediately, without waiting for clk:
- go to IDLE;
- set gnt=0, gnt_id=0, gnt_valid=0, busy=0, timeout=0;
- set hold_cnt=0 and last_id=3.
REQ-024 A reset during GRANT SHALL drop the grant in the same cycle with no RELEASE and no timeout pulse.
REQ-025 After rst_n rises, the first grant follows the IDLE rules on the next rising edge.

Configuration
REQ-026 Macro ARB_ROUND_ROBIN_EN defined: the winner is the first set req bit searching upward from last_id+1, wrapping 3 -> 0.
- With last_id=3 after reset, the search order is 0,1,2,3.
REQ-027 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, highest set bit wins (3 > 2 > 1 > 0); last_id is unused.

Verification
REQ-028 Fixed priority, req=4'b0110, done pulsed on the 3rd GRANT cycle -> gnt=4'b0100, gnt_id=2 for 3 cycles, then 1 RELEASE cycle with gnt=0, then IDLE.
REQ-029 Timeout, MAX_HOLD=4, req=4'b0001, done=0 -> gnt=4'b0001 for 4 cycles, then timeout=1 for 1 cycle, then regrant after IDLE.
REQ-030 ARB_ROUND_ROBIN_EN defined, req=4'b1111 held, done after 1 cycle each -> gnt_id sequence 0,1,2,3,0.
REQ-031 enable=0 with req=4'b1000 -> gnt stays 0; enable cleared mid-grant -> current grant runs to done.
REQ-032 Reset mid-grant, rst_n pulled low asynchronously during GRANT -> gnt=0 before the next clk edge, timeout=0.
REQ-033 Withdrawal, granted requester drops req in GRANT cycle 2 -> RELEASE on the next edge with timeout=0.
